// File: rtl/truth_table_scanner_pkg.sv
// Shared state encoding, table-width helper and hold-counter width for the
// truth table scanner and its hold timer.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } tts_state_t;

    localparam int HOLD_W = 4;

    function automatic int TT_W(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Settle-window timer: counts 0..HOLD_CYCLES-1 while enabled and flags the
// final count as the cycle on which the function output is sampled.
module tts_hold_timer
    import truth_table_scanner_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_sample_tick
);

    localparam logic [HOLD_W-1:0] LAST_COUNT = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] r_count;

    assign o_sample_tick = i_enable && (r_count == LAST_COUNT);

    // The count wraps on the sample tick so the next vector gets a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || o_sample_tick) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustive on-chip scan of an N-input combinational block into a truth table.
// Define TT_COMPARE_EN to add the expected-table comparison ports.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                f_in,
`ifdef TT_COMPARE_EN
    input  logic [TT_W(N)-1:0]  expected,
    output logic                mismatch,
    output logic [N-1:0]        first_bad,
`endif
    output logic [N-1:0]        w_out,
    output logic [TT_W(N)-1:0]  truth,
    output logic [N:0]          ones_cnt,
    output logic                busy,
    output logic                done
);

    localparam int            TTW      = TT_W(N);
    localparam logic [N-1:0]  LAST_IDX = N'(TTW - 1);

    tts_state_t     r_state;
    tts_state_t     w_nextState;
    logic           w_accept;
    logic           w_sampleTick;
    logic [N-1:0]   r_index;
    logic [TTW-1:0] r_truth;
    logic [N:0]     r_ones;

    tts_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_enable     (r_state == SCAN),
        .o_sample_tick(w_sampleTick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = SCAN;
                    w_accept    = 1'b1;
                end
            end
            SCAN: begin
                if (w_sampleTick && (r_index == LAST_IDX)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The index parks on the last vector so w_out keeps showing it after the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_truth <= '0;
            r_ones  <= '0;
        end else if (w_accept) begin
            r_index <= '0;
            r_truth <= '0;
            r_ones  <= '0;
        end else if (w_sampleTick) begin
            r_truth[r_index] <= f_in;
            r_ones           <= r_ones + {{N{1'b0}}, f_in};
            if (r_index != LAST_IDX) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

`ifdef TT_COMPARE_EN
    logic         r_mismatch;
    logic [N-1:0] r_firstBad;

    // Only the first disagreement is recorded; later ones leave first_bad alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
            r_firstBad <= '0;
        end else if (w_accept) begin
            r_mismatch <= 1'b0;
            r_firstBad <= '0;
        end else if (w_sampleTick && !r_mismatch && (f_in != expected[r_index])) begin
            r_mismatch <= 1'b1;
            r_firstBad <= r_index;
        end
    end

    assign mismatch  = r_mismatch;
    assign first_bad = r_firstBad;
`endif

    assign w_out    = r_index;
    assign truth    = r_truth;
    assign ones_cnt = r_ones;
    assign busy     = (r_state == SCAN);
    assign done     = (r_state == DONE);

endmodule
